// File: rtl/mini_alu_exec.sv
// Multi-cycle execute unit: start/done handshake around a small ALU, plus an optional
// iterative shift-add multiplier enabled by defining MINI_ALU_MUL_EN.
module mini_alu_exec #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEST_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [3:0]            iOp,
    input  logic [DATA_WIDTH-1:0] iData0,
    input  logic [DATA_WIDTH-1:0] iData1,
    input  logic [DEST_WIDTH-1:0] iDest,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [DATA_WIDTH-1:0] oResult,
    output logic [DATA_WIDTH-1:0] oResultHigh,
    output logic [DEST_WIDTH-1:0] oDest,
    output logic                  oZero,
    output logic                  oCarry,
    output logic                  oNegative,
    output logic                  oIllegal
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpAdd   = 4'd1;
    localparam logic [3:0] OpSub   = 4'd2;
    localparam logic [3:0] OpAnd   = 4'd3;
    localparam logic [3:0] OpOr    = 4'd4;
    localparam logic [3:0] OpXor   = 4'd5;
    localparam logic [3:0] OpShl   = 4'd6;
    localparam logic [3:0] OpShr   = 4'd7;
`ifdef MINI_ALU_MUL_EN
    localparam logic [3:0] OpMul   = 4'd8;
`endif
    localparam logic [3:0] OpCmple = 4'd9;

    typedef enum logic [1:0] {StIdle, StExec, StMulIter, StDone} state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] d0_q, d1_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic                  accept;

    logic [DATA_WIDTH-1:0] res, res_hi;
    logic [DATA_WIDTH:0]   sum, diff, shl_w, shr_w;
    logic [ShW-1:0]        shamt;
    logic                  carry, neg, zero, illegal;

    logic [DATA_WIDTH-1:0] result_q;
    logic [DEST_WIDTH-1:0] dest_out_q;
    logic                  done_q, zero_q, carry_q, neg_q, illegal_q;

    assign accept = (state_q == StIdle) && iStart;

`ifdef MINI_ALU_MUL_EN
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [ShW-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]   result_hi_q;

    // MSB-first shift-add: the accumulator doubles each step before the partial product lands.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
            cnt_q <= ShW'(DATA_WIDTH - 1);
        end else if (state_q == StMulIter) begin
            acc_q <= {acc_q[2*DATA_WIDTH-2:0], 1'b0}
                     + (d0_q[cnt_q] ? {{DATA_WIDTH{1'b0}}, d1_q} : '0);
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (iStart) begin
`ifdef MINI_ALU_MUL_EN
                    state_d = (iOp == OpMul) ? StMulIter : StExec;
`else
                    state_d = StExec;
`endif
                end
            end
            StExec: state_d = StDone;
            StMulIter: begin
`ifdef MINI_ALU_MUL_EN
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= iOp;
                d0_q   <= iData0;
                d1_q   <= iData1;
                dest_q <= iDest;
            end
        end
    end

    always_comb begin
        res     = '0;
        res_hi  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        shamt   = d0_q[ShW-1:0];
        sum     = {1'b0, d1_q} + {1'b0, d0_q};
        diff    = {1'b0, d1_q} - {1'b0, d0_q};
        // One guard bit on each side captures the last bit shifted out (0 for a zero shift).
        shl_w   = {1'b0, d1_q} << shamt;
        shr_w   = {d1_q, 1'b0} >> shamt;
        case (op_q)
            OpNop: res = '0;
            OpAdd: begin
                res   = sum[DATA_WIDTH-1:0];
                carry = sum[DATA_WIDTH];
            end
            OpSub: begin
                res   = diff[DATA_WIDTH-1:0];
                carry = diff[DATA_WIDTH];
            end
            OpAnd: res = d1_q & d0_q;
            OpOr:  res = d1_q | d0_q;
            OpXor: res = d1_q ^ d0_q;
            OpShl: begin
                res   = shl_w[DATA_WIDTH-1:0];
                carry = shl_w[DATA_WIDTH];
            end
            OpShr: begin
                res   = shr_w[DATA_WIDTH:1];
                carry = shr_w[0];
            end
`ifdef MINI_ALU_MUL_EN
            OpMul: begin
                res    = acc_q[DATA_WIDTH-1:0];
                res_hi = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
                carry  = (res_hi != '0);
            end
`endif
            OpCmple: res = {{(DATA_WIDTH-1){1'b0}}, (d1_q <= d0_q)};
            default: illegal = 1'b1;
        endcase
        neg = res[DATA_WIDTH-1];
`ifdef MINI_ALU_MUL_EN
        if (op_q == OpMul) begin
            neg = res_hi[DATA_WIDTH-1];
        end
`endif
        zero = (res == '0) && (res_hi == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            done_q     <= 1'b0;
            result_q   <= '0;
            dest_out_q <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            neg_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            if (state_q == StDone) begin
                result_q   <= res;
                dest_out_q <= dest_q;
                zero_q     <= zero;
                carry_q    <= carry;
                neg_q      <= neg;
                illegal_q  <= illegal;
            end
        end
    end

`ifdef MINI_ALU_MUL_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            result_hi_q <= '0;
        end else if (state_q == StDone) begin
            result_hi_q <= res_hi;
        end
    end
    assign oResultHigh = result_hi_q;
`else
    assign oResultHigh = '0;
`endif

    assign oBusy     = (state_q != StIdle);
    assign oDone     = done_q;
    assign oResult   = result_q;
    assign oDest     = dest_out_q;
    assign oZero     = zero_q;
    assign oCarry    = carry_q;
    assign oNegative = neg_q;
    assign oIllegal  = illegal_q;

endmodule

// File: tb/tb_mini_alu_exec.sv
// Directed self-checking bench for mini_alu_exec (DATA_WIDTH=16, DEST_WIDTH=8).
module tb_mini_alu_exec;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iStart = 1'b0;
    logic [3:0]  iOp = 4'h0;
    logic [15:0] iData0 = 16'h0;
    logic [15:0] iData1 = 16'h0;
    logic [7:0]  iDest = 8'h0;
    logic        oBusy, oDone, oZero, oCarry, oNegative, oIllegal;
    logic [15:0] oResult, oResultHigh;
    logic [7:0]  oDest;
    logic [43:0] got;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] d1;
        logic [15:0] d0;
        logic [7:0]  dest;
        logic [15:0] res;
        logic        z, c, n, il;
    } vec_t;

    mini_alu_exec #(.DATA_WIDTH(16), .DEST_WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iOp(iOp),
        .iData0(iData0), .iData1(iData1), .iDest(iDest),
        .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oResultHigh(oResultHigh),
        .oDest(oDest), .oZero(oZero), .oCarry(oCarry), .oNegative(oNegative),
        .oIllegal(oIllegal)
    );

    always #5 Clock = ~Clock;

    assign got = {oResultHigh, oResult, oDest, oZero, oCarry, oNegative, oIllegal};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one op (caller sits just after a clock edge) and returns cycles until oDone.
    task automatic run_op(input logic [3:0] op, input logic [15:0] d1, input logic [15:0] d0,
                          input logic [7:0] dest, output int lat);
        iStart = 1'b1; iOp = op; iData1 = d1; iData0 = d0; iDest = dest;
        @(posedge Clock); #1;
        iStart = 1'b0; iOp = 4'h0; iData1 = 16'hDEAD; iData0 = 16'hBEEF; iDest = 8'h55;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clock); #1;
            if (oDone === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        repeat (2) @(posedge Clock);
        #1;
        total_cnt++;
        if ({oBusy, oDone, got} !== 46'h0) $display("FAIL reset_init got %h want 0", {oBusy, oDone, got});
        else pass_cnt++;
        Reset = 1'b0;
        @(posedge Clock); #1;
        run_op(4'd1, 16'h1234, 16'h1111, 8'hA5, lat);
        #2 Reset = 1'b1;
        #1;
        total_cnt++;
        if ({oBusy, oDone, got} !== 46'h0) $display("FAIL reset_async got %h want 0", {oBusy, oDone, got});
        else pass_cnt++;
        @(posedge Clock); #2 Reset = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_single_ops();
        vec_t v[16];
        int lat;
        logic [43:0] exp;
        v[0]  = {4'd1, 16'hFFFF, 16'h0001, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        v[1]  = {4'd1, 16'h1234, 16'h1111, 8'h02, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
        v[2]  = {4'd2, 16'h0003, 16'h0005, 8'h03, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
        v[3]  = {4'd2, 16'h0009, 16'h0004, 8'h04, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
        v[4]  = {4'd3, 16'hFF0F, 16'h0FF0, 8'h05, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5]  = {4'd4, 16'hFF0F, 16'h0FF0, 8'h06, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        v[6]  = {4'd5, 16'hFF0F, 16'h0FF0, 8'h07, 16'hF0FF, 1'b0, 1'b0, 1'b1, 1'b0};
        v[7]  = {4'd6, 16'h8001, 16'h0001, 8'h08, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
        v[8]  = {4'd6, 16'h1234, 16'h0010, 8'h09, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        v[9]  = {4'd7, 16'h0003, 16'h0001, 8'h0A, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0};
        v[10] = {4'd7, 16'h8000, 16'h000F, 8'h0B, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        v[11] = {4'd9, 16'h0007, 16'h0007, 8'h0C, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        v[12] = {4'd9, 16'h0008, 16'h0007, 8'h0D, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        v[13] = {4'd0, 16'h1234, 16'h5678, 8'h0E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        v[14] = {4'hF, 16'h1234, 16'h5678, 8'h0F, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        v[15] = {4'hA, 16'hFFFF, 16'hFFFF, 8'h10, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            exp = {16'h0000, v[i].res, v[i].dest, v[i].z, v[i].c, v[i].n, v[i].il};
            run_op(v[i].op, v[i].d1, v[i].d0, v[i].dest, lat);
            total_cnt++;
            if (lat !== 2) $display("FAIL op%0d_latency got %0d want 2", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (got !== exp) $display("FAIL op%0d_outputs got %h want %h", i, got, exp);
            else pass_cnt++;
            @(posedge Clock); #1;
            total_cnt++;
            if ({oDone, got} !== {1'b0, exp})
                $display("FAIL op%0d_hold got %h want %h", i, {oDone, got}, {1'b0, exp});
            else pass_cnt++;
        end
    endtask

    task automatic test_mul();
        int lat;
`ifdef MINI_ALU_MUL_EN
        run_op(4'd8, 16'h1234, 16'h0100, 8'h2A, lat);
        total_cnt++;
        if (lat !== 17) $display("FAIL mul_latency got %0d want 17", lat);
        else pass_cnt++;
        total_cnt++;
        if (got !== {16'h0012, 16'h3400, 8'h2A, 4'b0100})
            $display("FAIL mul_basic got %h want %h", got, {16'h0012, 16'h3400, 8'h2A, 4'b0100});
        else pass_cnt++;
        run_op(4'd8, 16'hFFFF, 16'hFFFF, 8'h2B, lat);
        total_cnt++;
        if (got !== {16'hFFFE, 16'h0001, 8'h2B, 4'b0110})
            $display("FAIL mul_max got %h want %h", got, {16'hFFFE, 16'h0001, 8'h2B, 4'b0110});
        else pass_cnt++;
        run_op(4'd8, 16'h0000, 16'h0005, 8'h2C, lat);
        total_cnt++;
        if (got !== {16'h0000, 16'h0000, 8'h2C, 4'b1000})
            $display("FAIL mul_zero got %h want %h", got, {16'h0000, 16'h0000, 8'h2C, 4'b1000});
        else pass_cnt++;
`else
        run_op(4'd8, 16'h1234, 16'h0100, 8'h2A, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL mul_off_latency got %0d want 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (got !== {16'h0000, 16'h0000, 8'h2A, 4'b1001})
            $display("FAIL mul_off_illegal got %h want %h", got, {16'h0000, 16'h0000, 8'h2A, 4'b1001});
        else pass_cnt++;
`endif
        @(posedge Clock); #1;
    endtask

    task automatic test_ignored_start();
        int dones;
        logic [43:0] first;
        logic [43:0] exp;
`ifdef MINI_ALU_MUL_EN
        exp = {16'h0012, 16'h3400, 8'h2A, 4'b0100};
        iStart = 1'b1; iOp = 4'd8; iData1 = 16'h1234; iData0 = 16'h0100; iDest = 8'h2A;
        @(posedge Clock); #1;
        iStart = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
`else
        exp = {16'h0000, 16'h0008, 8'h2A, 4'b0000};
        iStart = 1'b1; iOp = 4'd1; iData1 = 16'h0005; iData0 = 16'h0003; iDest = 8'h2A;
        @(posedge Clock); #1;
`endif
        iStart = 1'b1; iOp = 4'd2; iData1 = 16'h0001; iData0 = 16'h0009; iDest = 8'h77;
        @(posedge Clock); #1;
        iStart = 1'b0;
        dones = 0;
        first = '0;
        for (int k = 0; k < 30; k++) begin
            if (oDone === 1'b1) begin
                if (dones == 0) first = got;
                dones++;
            end
            @(posedge Clock); #1;
        end
        total_cnt++;
        if (dones !== 1) $display("FAIL ignored_start_done_count got %0d want 1", dones);
        else pass_cnt++;
        total_cnt++;
        if (first !== exp) $display("FAIL ignored_start_result got %h want %h", first, exp);
        else pass_cnt++;
        total_cnt++;
        if (oBusy !== 1'b0) $display("FAIL ignored_start_idle got %b want 0", oBusy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(4'd1, 16'h0001, 16'h0002, 8'h31, lat);
        total_cnt++;
        if (got !== {16'h0000, 16'h0003, 8'h31, 4'b0000})
            $display("FAIL b2b_first got %h want %h", got, {16'h0000, 16'h0003, 8'h31, 4'b0000});
        else pass_cnt++;
        // Start issued during the oDone cycle must be accepted.
        run_op(4'd2, 16'h0010, 16'h0001, 8'h32, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL b2b_latency got %0d want 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (got !== {16'h0000, 16'h000F, 8'h32, 4'b0000})
            $display("FAIL b2b_second got %h want %h", got, {16'h0000, 16'h000F, 8'h32, 4'b0000});
        else pass_cnt++;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_abort();
        int dones;
        iStart = 1'b1; iData1 = 16'h1234; iData0 = 16'h0100; iDest = 8'h3C;
`ifdef MINI_ALU_MUL_EN
        iOp = 4'd8;
        @(posedge Clock); #1;
        iStart = 1'b0;
        repeat (4) @(posedge Clock);
`else
        iOp = 4'd1;
        @(posedge Clock); #1;
        iStart = 1'b0;
`endif
        #2 Reset = 1'b1;
        #1;
        total_cnt++;
        if ({oBusy, oDone, got} !== 46'h0) $display("FAIL abort_reset got %h want 0", {oBusy, oDone, got});
        else pass_cnt++;
        @(posedge Clock); #2 Reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge Clock); #1;
            if (oDone === 1'b1) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones);
        else pass_cnt++;
        total_cnt++;
        if ({oBusy, got} !== 45'h0) $display("FAIL abort_no_result got %h want 0", {oBusy, got});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
